// File: rtl/lvl_sequencer_pkg.sv
// Shared types for the MoonLanders level sequencer.
// Holds the game-flow state encoding, the display level codes and the lives field width.
package moon_pkg;

  typedef enum logic [2:0] {
    TITLE,
    PLAY,
    PAUSE_OK,
    PAUSE_CRASH,
    WIN,
    OVER
  } state_t;

  localparam logic [2:0]  LVL_TITLE = 3'd0;
  localparam logic [2:0]  LVL_WIN   = 3'd4;
  localparam int unsigned LIVES_W   = 2;

endpackage

// File: rtl/lvl_sequencer_if.sv
// Game-flow bus between the lander datapath/keys and the level sequencer.
// The sequencer uses the slave modport; the environment drives through master.
interface lvl_sequencer_if;
  import moon_pkg::*;

  logic               start;
  logic               landed;
  logic               crashed;
  logic [2:0]         level;
  logic               game_active;
  logic               round_start;
  logic [LIVES_W-1:0] lives;
  logic               game_over;

  modport master (
    output start, landed, crashed,
    input  level, game_active, round_start, lives, game_over
  );

  modport slave (
    input  start, landed, crashed,
    output level, game_active, round_start, lives, game_over
  );

endinterface

// File: rtl/lvl_sequencer_pause_timer.sv
// Inter-round pause counter: cleared while idle, counts while enabled,
// done flags the last cycle of a PAUSE_CYCLES-long pause.
module pause_timer #(
  parameter int unsigned PAUSE_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = $clog2(PAUSE_CYCLES);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!Reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign done = (count_q == CW'(PAUSE_CYCLES - 1));

endmodule

// File: rtl/lvl_sequencer.sv
// MoonLanders game-flow FSM: title -> levels -> win, with timed pauses between rounds.
// Optional lives/game-over support is built when MOON_LIVES_EN is defined.
module lvl_sequencer
  import moon_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES = 50_000_000,
  parameter int unsigned MAX_LEVEL    = 3,
  parameter int unsigned NUM_LIVES    = 3
) (
  input  logic            clock,
  input  logic            Reset,
  lvl_sequencer_if.slave  bus
);

  if (PAUSE_CYCLES < 2 || MAX_LEVEL < 1 || MAX_LEVEL > 3 ||
      NUM_LIVES < 1 || NUM_LIVES > 3) begin : g_bad_param
    $error("lvl_sequencer: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [2:0] level_q, level_d;
  logic       game_active_q, game_active_d;
  logic       round_start_q, round_start_d;
  logic       armed_q, armed_d;
  logic       in_pause;
  logic       pause_done;
`ifdef MOON_LIVES_EN
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               game_over_q, game_over_d;
`endif

  assign in_pause = (state_q == PAUSE_OK) || (state_q == PAUSE_CRASH);

  pause_timer #(.PAUSE_CYCLES(PAUSE_CYCLES)) u_pause_timer (
    .clock  (clock),
    .Reset  (Reset),
    .clear  (!in_pause),
    .enable (in_pause),
    .done   (pause_done)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    // A start key held across WIN/OVER -> TITLE must be released before it counts again.
    armed_d = armed_q | ~bus.start;
`ifdef MOON_LIVES_EN
    lives_d = lives_q;
`endif
    unique case (state_q)
      TITLE: begin
        if (bus.start && armed_q) begin
          state_d = PLAY;
          level_d = 3'd1;
`ifdef MOON_LIVES_EN
          lives_d = LIVES_W'(NUM_LIVES);
`endif
        end
      end
      PLAY: begin
        if (bus.crashed) begin
          state_d = PAUSE_CRASH;
`ifdef MOON_LIVES_EN
          if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
`endif
        end else if (bus.landed) begin
          state_d = PAUSE_OK;
        end
      end
      PAUSE_OK: begin
        if (pause_done) begin
          if (level_q < 3'(MAX_LEVEL)) begin
            state_d = PLAY;
            level_d = level_q + 3'd1;
          end else begin
            state_d = WIN;
            level_d = LVL_WIN;
          end
        end
      end
      PAUSE_CRASH: begin
        if (pause_done) begin
`ifdef MOON_LIVES_EN
          if (lives_q != '0) begin
            state_d = PLAY;
          end else begin
            state_d = OVER;
            level_d = LVL_TITLE;
          end
`else
          state_d = PLAY;
`endif
        end
      end
      WIN, OVER: begin
        if (bus.start) begin
          state_d = TITLE;
          level_d = LVL_TITLE;
          armed_d = 1'b0;
        end
      end
      default: begin
        state_d = TITLE;
        level_d = LVL_TITLE;
      end
    endcase
    game_active_d = (state_d == PLAY);
    round_start_d = (state_d == PLAY) && (state_q != PLAY);
`ifdef MOON_LIVES_EN
    game_over_d   = (state_d == OVER);
`endif
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q       <= TITLE;
      level_q       <= LVL_TITLE;
      game_active_q <= 1'b0;
      round_start_q <= 1'b0;
      armed_q       <= 1'b1;
`ifdef MOON_LIVES_EN
      lives_q       <= LIVES_W'(NUM_LIVES);
      game_over_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      game_active_q <= game_active_d;
      round_start_q <= round_start_d;
      armed_q       <= armed_d;
`ifdef MOON_LIVES_EN
      lives_q       <= lives_d;
      game_over_q   <= game_over_d;
`endif
    end
  end

  assign bus.level       = level_q;
  assign bus.game_active = game_active_q;
  assign bus.round_start = round_start_q;
`ifdef MOON_LIVES_EN
  assign bus.lives       = lives_q;
  assign bus.game_over   = game_over_q;
`else
  assign bus.lives       = '0;
  assign bus.game_over   = 1'b0;
`endif

endmodule
